// File: rtl/i2s_tdm_transmitter.sv
// Philips I2S/TDM transmitter: one-frame holding buffer (ready = !full), sd/ws registered on the sclk falling edge; slave sd lags sclkIn fall by 3 clk.
// Optional slave path (external sclkIn/wsIn, ws realignment) is compiled in by defining I2S_TX_SLAVE_EN.
module i2s_tdm_transmitter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_OF_CHANNEL = 2,
  parameter int SLOT_WIDTH     = 16,
  parameter int CLK_DIV        = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic                                 txMaster,
  input  logic [NUM_OF_CHANNEL*DATA_WIDTH-1:0] frameData,
  input  logic                                 frameValid,
  output logic                                 frameReady,
  input  logic                                 sclkIn,
  input  logic                                 wsIn,
  output logic                                 sclkOut,
  output logic                                 wsOut,
  output logic                                 sd,
  output logic                                 underrun,
  output logic                                 busy
);
  localparam int FRAME = NUM_OF_CHANNEL * SLOT_WIDTH;
  localparam int FW    = NUM_OF_CHANNEL * DATA_WIDTH;
  localparam int BW    = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int DIVW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0]   BIT_LAST = BW'(FRAME - 1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLK_DIV / 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          r_state;
  logic [DIVW-1:0] r_div;
  logic [BW-1:0]   r_bit_cnt;
  logic [FW-1:0]   r_buf;
  logic [FW-1:0]   r_frame;
  logic            r_buf_full;
  logic            r_sclk_out;
  logic            r_ws_out;
  logic            r_sd;
  logic            r_underrun;

  logic            w_master;
  logic            w_tick;
  logic            w_realign;
  logic            w_wrap;
  logic            w_load;
  logic            w_stop;
  logic            w_div_run;
  logic [DIVW-1:0] w_div_next;
  logic [FW-1:0]   w_frame_next;
  logic [BW-1:0]   w_cnt_next;

  function automatic logic f_sd_bit(input logic [FW-1:0] frame, input logic [BW-1:0] cnt);
    int            s;
    int            k;
    logic [FW-1:0] sh;
    s = int'(cnt) / SLOT_WIDTH;
    k = int'(cnt) % SLOT_WIDTH;
    if (k >= DATA_WIDTH) return 1'b0;
    sh = frame >> (s * DATA_WIDTH + DATA_WIDTH - 1 - k);
    return sh[0];
  endfunction

  // ws leads sd by one bit: it reflects the slot of the next bit position
  function automatic logic f_ws(input logic [BW-1:0] cnt);
    return ((int'(cnt) + 1) % FRAME) >= (FRAME / 2);
  endfunction

`ifdef I2S_TX_SLAVE_EN
  logic       r_sclk_s1;
  logic       r_sclk_s2;
  logic       r_sclk_d;
  logic       r_ws_s1;
  logic       r_ws_s2;
  logic [1:0] r_ws_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_ws_s1   <= 1'b0;
      r_ws_s2   <= 1'b0;
      r_ws_hist <= 2'b00;
    end else begin
      r_sclk_s1 <= sclkIn;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_ws_s1   <= wsIn;
      r_ws_s2   <= r_ws_s1;
      if (!r_sclk_d && r_sclk_s2) r_ws_hist <= {r_ws_hist[0], r_ws_s2};
    end
  end

  assign w_master  = txMaster;
  assign w_tick    = w_master ? (r_div == DIV_LAST) : (r_sclk_d && !r_sclk_s2);
  assign w_realign = !w_master && (r_ws_hist == 2'b10);
`else
  logic w_unused;
  assign w_unused  = &{1'b0, txMaster, sclkIn, wsIn};
  assign w_master  = 1'b1;
  assign w_tick    = (r_div == DIV_LAST);
  assign w_realign = 1'b0;
`endif

  assign w_wrap       = (r_bit_cnt == BIT_LAST);
  assign w_load       = w_tick && (((r_state == RUN) && w_realign) || (w_wrap && enable));
  assign w_stop       = w_tick && (r_state == RUN) && w_wrap && !enable && !w_realign;
  assign w_div_run    = w_master && (enable || (r_state == RUN));
  assign w_div_next   = (!w_div_run || (r_div == DIV_LAST)) ? '0 : r_div + 1'b1;
  assign w_frame_next = !w_load ? r_frame : (r_buf_full ? r_buf : '0);
  assign w_cnt_next   = w_load ? '0 : r_bit_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_bit_cnt  <= BIT_LAST;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_frame    <= '0;
      r_sclk_out <= 1'b0;
      r_ws_out   <= 1'b0;
      r_sd       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_div      <= w_div_next;
      r_underrun <= w_load && !r_buf_full;
      // an accept coinciding with a load refills the buffer, so full wins over the load clear
      if (frameValid && !r_buf_full) begin
        r_buf      <= frameData;
        r_buf_full <= 1'b1;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end
      if (w_stop) begin
        r_state   <= IDLE;
        r_bit_cnt <= BIT_LAST;
        r_sd      <= 1'b0;
        r_ws_out  <= 1'b0;
      end else if (w_tick && (w_load || (r_state == RUN))) begin
        r_state   <= RUN;
        r_bit_cnt <= w_cnt_next;
        r_frame   <= w_frame_next;
        r_sd      <= f_sd_bit(w_frame_next, w_cnt_next);
        r_ws_out  <= w_master && f_ws(w_cnt_next);
      end
      r_sclk_out <= w_master && (w_load || ((r_state == RUN) && !w_stop)) && (w_div_next >= DIV_HALF);
    end
  end

  assign frameReady = !r_buf_full;
  assign sclkOut    = r_sclk_out;
  assign wsOut      = r_ws_out;
  assign sd         = r_sd;
  assign underrun   = r_underrun;
  assign busy       = (r_state == RUN);

endmodule

// File: tb/tb_i2s_tdm_transmitter.sv
// Directed bench for i2s_tdm_transmitter at default parameters; slave checks compile only with I2S_TX_SLAVE_EN.
module tb_i2s_tdm_transmitter;
  logic        clk;
  logic        rst;
  logic        enable;
  logic        txMaster;
  logic [15:0] frameData;
  logic        frameValid;
  logic        frameReady;
  logic        sclkIn;
  logic        wsIn;
  logic        sclkOut;
  logic        wsOut;
  logic        sd;
  logic        underrun;
  logic        busy;

  int          n_checks;
  int          n_pass;
  int          idx;
  logic [15:0] tbl [3];

  i2s_tdm_transmitter dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .txMaster   (txMaster),
    .frameData  (frameData),
    .frameValid (frameValid),
    .frameReady (frameReady),
    .sclkIn     (sclkIn),
    .wsIn       (wsIn),
    .sclkOut    (sclkOut),
    .wsOut      (wsOut),
    .sd         (sd),
    .underrun   (underrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (!busy && n < 64) begin
      step();
      n++;
    end
    check("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  // Starts just after a load edge; ends just after the next tick edge (128 clk later).
  task automatic run_frame(input int feed_from, input int drop_bit,
                           output logic [31:0] sd_v, output logic [31:0] ws_v,
                           output int sclk_bad, output int und_cnt);
    logic acc;
    sd_v = '0; ws_v = '0; sclk_bad = 0; und_cnt = 0;
    for (int c = 0; c < 128; c++) begin
      if (c % 4 == 0) begin
        sd_v[31 - c / 4] = sd;
        ws_v[31 - c / 4] = wsOut;
      end
      if (sclkOut !== ((c % 4) >= 2)) sclk_bad++;
      if (underrun) und_cnt++;
      if (c == drop_bit * 4) enable = 0;
      if (feed_from >= 0 && c >= feed_from && idx < 3) begin
        frameValid = 1;
        frameData  = tbl[idx];
      end else begin
        frameValid = 0;
      end
      acc = frameValid && frameReady;
      step();
      if (acc) idx++;
    end
  endtask

  task automatic frame_checks(input string tag, input logic [31:0] exp_sd, input int exp_und);
    logic [31:0] sdv;
    logic [31:0] wsv;
    int          sb;
    int          uc;
    run_frame(0, -1, sdv, wsv, sb, uc);
    check({tag, "_sd"}, sdv, exp_sd);
    check({tag, "_ws"}, wsv, 32'h0001FFFE);
    check({tag, "_sclk"}, sb, 0);
    check({tag, "_underrun"}, uc, exp_und);
  endtask

`ifdef I2S_TX_SLAVE_EN
  task automatic slave_bit(input logic ws_val, output logic sd_early, output logic sd_at3);
    sclkIn = 0;
    wsIn   = ws_val;
    step();
    step();
    sd_early = sd;
    step();
    sd_at3 = sd;
    repeat (5) step();
    sclkIn = 1;
    repeat (8) step();
  endtask
`endif

  initial begin
    logic [31:0] sdv;
    logic [31:0] wsv;
    int          sb;
    int          uc;
    int          lat;
    int          busy_hi;
    logic        e;
    logic        a;
    logic [7:0]  v;
    n_checks = 0; n_pass = 0; idx = 0;
    tbl[0] = 16'h0FF0; tbl[1] = 16'h8001; tbl[2] = 16'hFFFF;
    clk = 0; rst = 1; enable = 0; txMaster = 1; frameData = '0; frameValid = 0;
    sclkIn = 0; wsIn = 0;
    repeat (2) step();
    check("rst_sclk", {31'd0, sclkOut}, 0);
    check("rst_ws", {31'd0, wsOut}, 0);
    check("rst_sd", {31'd0, sd}, 0);
    check("rst_underrun", {31'd0, underrun}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {31'd0, frameReady}, 1);
    rst = 0;
    step();

    // Frame A = ch0 A5, ch1 3C
    frameValid = 1; frameData = 16'h3CA5;
    step();
    frameValid = 0;
    check("ready_after_accept", {31'd0, frameReady}, 0);
    enable = 1;
    wait_busy(lat);
    check("first_tick_latency", lat, 4);
    check("ready_on_load", {31'd0, frameReady}, 1);
    run_frame(127, -1, sdv, wsv, sb, uc);
    check("a_sd", sdv, 32'hA5003C00);
    check("a_ws", wsv, 32'h0001FFFE);
    check("a_sclk", sb, 0);
    check("a_underrun", uc, 0);
    check("frame_len_underrun", {31'd0, underrun}, 1);
    check("accept_with_load_full", {31'd0, frameReady}, 0);

    frame_checks("zero", 32'h00000000, 1);
    check("b2b_ready_on_load", {31'd0, frameReady}, 1);
    frame_checks("b", 32'hF0000F00, 0);
    frame_checks("c", 32'h01008000, 0);

    // Frame D with enable dropped at bit 5: the frame still completes
    run_frame(0, 5, sdv, wsv, sb, uc);
    check("d_sd", sdv, 32'hFF00FF00);
    check("d_sclk", sb, 0);
    check("d_underrun", uc, 0);
    check("stop_busy", {31'd0, busy}, 0);
    check("stop_sclk", {31'd0, sclkOut}, 0);
    check("stop_ws", {31'd0, wsOut}, 0);
    busy_hi = 0;
    repeat (12) begin
      step();
      if (busy || sclkOut || wsOut) busy_hi++;
    end
    check("idle_hold", busy_hi, 0);

    // Reset mid-frame discards the running frame and the buffered one
    frameValid = 1; frameData = 16'h5AC3;
    step();
    frameValid = 0;
    enable = 1;
    wait_busy(lat);
    frameValid = 1; frameData = 16'h1234;
    step();
    frameValid = 0;
    repeat (29) step();
    check("pre_rst_sd", {31'd0, sd}, 1);
    check("pre_rst_sclk", {31'd0, sclkOut}, 1);
    rst = 1; enable = 0;
    #1;
    check("midrst_sclk", {31'd0, sclkOut}, 0);
    check("midrst_sd", {31'd0, sd}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_ready", {31'd0, frameReady}, 1);
    step();
    rst = 0;
    frameValid = 1; frameData = 16'h6996;
    step();
    frameValid = 0;
    enable = 1;
    wait_busy(lat);
    check("restart_latency", lat, 4);
    run_frame(-1, -1, sdv, wsv, sb, uc);
    check("restart_sd", sdv, 32'h96006900);
    check("restart_underrun", uc, 0);

`ifdef I2S_TX_SLAVE_EN
    rst = 1; enable = 0; txMaster = 0; sclkIn = 1; wsIn = 1; frameValid = 0;
    step();
    rst = 0;
    frameValid = 1; frameData = 16'h4EB1;
    step();
    frameValid = 0;
    repeat (3) slave_bit(1, e, a);
    slave_bit(0, e, a);
    enable = 1;
    frameValid = 1; frameData = 16'h00C7;
    slave_bit(0, e, a);
    frameValid = 0;
    check("slv_sd_before_3clk", {31'd0, e}, 0);
    check("slv_msb_at_3clk", {31'd0, a}, 1);
    v[7] = a;
    for (int i = 6; i >= 0; i--) begin
      slave_bit(0, e, a);
      v[i] = a;
    end
    check("slv_ch0", {24'd0, v}, 32'h000000B1);
    slave_bit(1, e, a);
    v[1] = a;
    slave_bit(0, e, a);
    v[0] = a;
    check("slv_padding", {30'd0, v[1:0]}, 0);
    for (int i = 7; i >= 0; i--) begin
      slave_bit(0, e, a);
      v[i] = a;
    end
    check("slv_realign", {24'd0, v}, 32'h000000C7);
    check("slv_outs_quiet", {30'd0, sclkOut, wsOut}, 0);
    check("slv_busy", {31'd0, busy}, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
